// File: rtl/mse_bus_pkg.sv
// Shared types and constants for the MSE parallel-bus initiator.
package mse_bus_pkg;

    localparam int BUS_AW = 8;
    localparam int BUS_DW = 8;

    // Default bus timing, in clock cycles.
    localparam int DEF_SETUP_CYC   = 1;
    localparam int DEF_STROBE_CYC  = 2;
    localparam int DEF_HOLD_CYC    = 1;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Byte returned to the CPU when a read gives up on a stuck target.
    localparam logic [BUS_DW-1:0] DEF_TIMEOUT_DATA = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } bus_state_t;

endpackage

// File: rtl/mse_sync2.sv
// Two-flop synchroniser for a single asynchronous control input.
module mse_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/mse_bus_initiator.sv
// Avalon-MM slave that turns each read/write into one timed MSE bus cycle:
// setup, strobe (stretched by WAIT, bounded by a timeout), hold.
module mse_bus_initiator
    import mse_bus_pkg::*;
#(
    parameter int                SETUP_CYC    = DEF_SETUP_CYC,
    parameter int                STROBE_CYC   = DEF_STROBE_CYC,
    parameter int                HOLD_CYC     = DEF_HOLD_CYC,
    parameter int                TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter logic [BUS_DW-1:0] TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
    input  logic              csi_MCLK_clk,
    input  logic              rsi_MRST_reset_n,
    input  logic [BUS_AW-1:0] avs_S1_address,
    input  logic              avs_S1_read,
    input  logic              avs_S1_write,
    input  logic [31:0]       avs_S1_writedata,
    input  logic [3:0]        avs_S1_byteenable,
    output logic [31:0]       avs_S1_readdata,
    output logic              avs_S1_waitrequest,
    output logic [BUS_AW-1:0] coe_S1_ADDR,
    inout  wire  [BUS_DW-1:0] coe_S1_DATA,
    output logic              coe_S1_RD,
    output logic              coe_S1_WR,
    input  logic              coe_S1_WAIT,
    output logic              coe_S1_TIMEOUT
);

    // "Last cycle" indices for each phase, compared against the 8-bit counter.
    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    bus_state_t        state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [7:0]        tcnt, tcnt_nxt;
    logic              take_req, strobe_exit, to_hit;
    logic              is_wr, is_wr_nxt, drive_nxt;
    logic              wait_s;
    logic [BUS_DW-1:0] wdata_q, rdata_q;
    logic              data_oe;

    // Upper write lanes and byte enables carry nothing for an 8-bit bus.
    logic unused_lanes;
    assign unused_lanes = ^{avs_S1_writedata[31:8], avs_S1_byteenable[3:1]};

    mse_sync2 u_wait_sync (
        .clk   (csi_MCLK_clk),
        .rst_n (rsi_MRST_reset_n),
        .d     (coe_S1_WAIT),
        .q     (wait_s)
    );

    assign coe_S1_DATA     = data_oe ? wdata_q : {BUS_DW{1'bz}};
    assign avs_S1_readdata = {24'h0, rdata_q};

    // Next-state logic: phase counters, WAIT stretching and timeout exit.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tcnt_nxt    = tcnt;
        take_req    = 1'b0;
        strobe_exit = 1'b0;
        to_hit      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt  = 8'd0;
                tcnt_nxt = 8'd0;
                if (avs_S1_write) begin
                    take_req  = 1'b1;
                    state_nxt = avs_S1_byteenable[0] ? SETUP : DONE;
                end else if (avs_S1_read) begin
                    take_req  = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt >= SETUP_LAST) begin
                    state_nxt = STROBE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            STROBE: begin
                if (cnt < STROBE_LAST) begin
                    cnt_nxt = sat_inc(cnt);
                end else if (!wait_s) begin
                    strobe_exit = 1'b1;
                end else if (tcnt >= TIMEOUT_LIM) begin
                    strobe_exit = 1'b1;
                    to_hit      = 1'b1;
                end else begin
                    tcnt_nxt = sat_inc(tcnt);
                end
                if (strobe_exit) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 8'd0;
                end
            end
            HOLD: begin
                if (cnt >= HOLD_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A request latched this edge decides direction for the new cycle.
        is_wr_nxt = take_req ? avs_S1_write : is_wr;
        drive_nxt = is_wr_nxt &&
                    ((state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD));
    end

    // FSM state and counters.
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            tcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // Registered bus and Avalon outputs, all derived from the next state so
    // they line up with the state they belong to.
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            is_wr              <= 1'b0;
            wdata_q            <= '0;
            coe_S1_ADDR        <= '0;
            data_oe            <= 1'b0;
            coe_S1_RD          <= 1'b0;
            coe_S1_WR          <= 1'b0;
            avs_S1_waitrequest <= 1'b1;
            rdata_q            <= '0;
            coe_S1_TIMEOUT     <= 1'b0;
        end else begin
            if (take_req) begin
                coe_S1_ADDR <= avs_S1_address;
                wdata_q     <= avs_S1_writedata[BUS_DW-1:0];
            end
            is_wr              <= is_wr_nxt;
            data_oe            <= drive_nxt;
            coe_S1_RD          <= (state_nxt == STROBE) && !is_wr_nxt;
            coe_S1_WR          <= (state_nxt == STROBE) && is_wr_nxt;
            avs_S1_waitrequest <= (state_nxt != DONE);
            // Capture on the same edge that drops the strobe, while the
            // target is still driving.
            if (strobe_exit && !is_wr) begin
                rdata_q <= to_hit ? TIMEOUT_DATA : coe_S1_DATA;
            end
            if (to_hit) begin
                coe_S1_TIMEOUT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mse_bus_initiator.sv
// Bench for mse_bus_initiator: one default instance and one with a short
// timeout, driven through a shared Avalon master steered by sel.
module tb_mse_bus_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic [7:0]  av_addr;
    logic        av_rd, av_wr;
    logic [31:0] av_wdata;
    logic [3:0]  av_be;
    logic        wait_drv;
    logic [7:0]  tgt_data;

    logic [31:0] a_rdata, b_rdata;
    logic        a_wreq, b_wreq;
    logic [7:0]  a_addr, b_addr;
    logic        a_rd, a_wr, b_rd, b_wr, a_to, b_to;
    wire  [7:0]  a_data, b_data;

    // Target side: drives the byte while the read strobe is high.
    assign a_data = a_rd ? tgt_data : 8'hzz;
    assign b_data = b_rd ? tgt_data : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (a_data[i]);
        pullup (b_data[i]);
    end

    mse_bus_initiator dut_a (
        .csi_MCLK_clk       (clk),
        .rsi_MRST_reset_n   (rst_n),
        .avs_S1_address     (av_addr),
        .avs_S1_read        (av_rd & ~sel),
        .avs_S1_write       (av_wr & ~sel),
        .avs_S1_writedata   (av_wdata),
        .avs_S1_byteenable  (av_be),
        .avs_S1_readdata    (a_rdata),
        .avs_S1_waitrequest (a_wreq),
        .coe_S1_ADDR        (a_addr),
        .coe_S1_DATA        (a_data),
        .coe_S1_RD          (a_rd),
        .coe_S1_WR          (a_wr),
        .coe_S1_WAIT        (wait_drv & ~sel),
        .coe_S1_TIMEOUT     (a_to)
    );

    mse_bus_initiator #(.TIMEOUT_CYC(4)) dut_b (
        .csi_MCLK_clk       (clk),
        .rsi_MRST_reset_n   (rst_n),
        .avs_S1_address     (av_addr),
        .avs_S1_read        (av_rd & sel),
        .avs_S1_write       (av_wr & sel),
        .avs_S1_writedata   (av_wdata),
        .avs_S1_byteenable  (av_be),
        .avs_S1_readdata    (b_rdata),
        .avs_S1_waitrequest (b_wreq),
        .coe_S1_ADDR        (b_addr),
        .coe_S1_DATA        (b_data),
        .coe_S1_RD          (b_rd),
        .coe_S1_WR          (b_wr),
        .coe_S1_WAIT        (wait_drv & sel),
        .coe_S1_TIMEOUT     (b_to)
    );

    logic [31:0] rdata_m;
    logic        wreq_m, rd_m, wr_m, to_m;
    logic [7:0]  addr_m, data_m;
    assign rdata_m = sel ? b_rdata : a_rdata;
    assign wreq_m  = sel ? b_wreq  : a_wreq;
    assign rd_m    = sel ? b_rd    : a_rd;
    assign wr_m    = sel ? b_wr    : a_wr;
    assign to_m    = sel ? b_to    : a_to;
    assign addr_m  = sel ? b_addr  : a_addr;
    assign data_m  = sel ? b_data  : a_data;

    typedef struct {
        bit          sel;
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [3:0]  be;
        logic [7:0]  tgt;
        int          wait_n;     // WAIT high for cycles 0..wait_n-1
        int          drop_at;    // cycle the master drops its request (0: hold)
        int          exp_rd;     // RD-high cycle count
        int          exp_wr;     // WR-high cycle count
        int          exp_lat;    // cycle in which waitrequest is low
        logic [31:0] exp_rdata;
        bit          exp_to;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] sb_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, rd_n, wr_n, first;
        bit done;
        @(negedge clk);
        sel      = v.sel;
        av_addr  = v.addr;
        av_rd    = v.rd;
        av_wr    = v.wr;
        av_wdata = {24'hDEADBE, v.wdata};
        av_be    = v.be;
        tgt_data = v.tgt;
        wait_drv = (v.wait_n > 0);
        if (v.rd && !v.wr) sb_q.push_back(v.exp_rdata);
        cyc = 0; rd_n = 0; wr_n = 0; first = -1; done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            wait_drv = (cyc < v.wait_n);
            if (v.drop_at != 0 && cyc == v.drop_at) begin
                av_rd = 1'b0;
                av_wr = 1'b0;
            end
            if (rd_m || wr_m) begin
                if (first < 0) first = cyc;
                check("strobe_addr", 32'(addr_m), 32'(v.addr));
            end
            if (rd_m) rd_n++;
            if (wr_m) begin
                wr_n++;
                check("write_data", 32'(data_m), 32'(v.wdata));
            end
            if (!v.wr && !rd_m) check("read_bus_undriven", 32'(data_m), 32'hFF);
            if (!wreq_m) begin
                done = 1'b1;
                check("latency", 32'(cyc), 32'(v.exp_lat));
                if (v.rd && !v.wr) begin
                    if (sb_q.size() == 0) check("scoreboard_empty", 32'(0), 32'(1));
                    else check("readdata", rdata_m, sb_q.pop_front());
                end
            end
        end
        if (!done) check("completion_budget", 32'(cyc), 32'(v.exp_lat));
        @(negedge clk);
        av_rd = 1'b0; av_wr = 1'b0; wait_drv = 1'b0;
        check("data_released", 32'(data_m), 32'hFF);
        check("waitrequest_back", 32'(wreq_m), 32'(1));
        check("rd_len", 32'(rd_n), 32'(v.exp_rd));
        check("wr_len", 32'(wr_n), 32'(v.exp_wr));
        if (v.exp_rd + v.exp_wr > 0) check("strobe_start", 32'(first), 32'(2));
        check("timeout_flag", 32'(to_m), 32'(v.exp_to));
    endtask

    initial begin
        //              sel rd wr addr   wdata  be       tgt    W    drop rd  wr lat rdata          to
        vecs[0] = '{1'b0,1'b0,1'b1,8'h12,8'hA5,4'b0001,8'h00,  0,   0,  0, 2, 5, 32'h0,         1'b0};
        vecs[1] = '{1'b0,1'b1,1'b0,8'h34,8'h00,4'b0000,8'h5C,  0,   0,  2, 0, 5, 32'h0000005C,  1'b0};
        vecs[2] = '{1'b0,1'b1,1'b0,8'h56,8'h00,4'b0000,8'h3C, 11,   0, 12, 0,15, 32'h0000003C,  1'b0};
        vecs[3] = '{1'b0,1'b0,1'b1,8'h78,8'h99,4'b1110,8'h00,  0,   0,  0, 0, 1, 32'h0,         1'b0};
        vecs[4] = '{1'b0,1'b1,1'b1,8'h9A,8'h3C,4'b0001,8'h11,  0,   0,  0, 2, 5, 32'h0,         1'b0};
        vecs[5] = '{1'b0,1'b1,1'b0,8'hC3,8'h00,4'b0000,8'h81,  2,   0,  3, 0, 6, 32'h00000081,  1'b0};
        vecs[6] = '{1'b0,1'b0,1'b1,8'hE1,8'h6D,4'b1111,8'h00,  3,   0,  0, 4, 7, 32'h0,         1'b0};
        vecs[7] = '{1'b0,1'b1,1'b0,8'h11,8'h00,4'b0000,8'hE7,  0,   1,  2, 0, 5, 32'h000000E7,  1'b0};
        vecs[8] = '{1'b1,1'b1,1'b0,8'h01,8'h00,4'b0000,8'h5A,100,   0,  6, 0, 9, 32'h000000FF,  1'b1};
        vecs[9] = '{1'b1,1'b1,1'b0,8'h02,8'h00,4'b0000,8'h42,  0,   0,  2, 0, 5, 32'h00000042,  1'b1};

        rst_n = 1'b0; sel = 1'b0; av_addr = '0; av_rd = 1'b0; av_wr = 1'b0;
        av_wdata = '0; av_be = '0; wait_drv = 1'b0; tgt_data = '0;
        repeat (3) @(negedge clk);
        check("rst_waitrequest", 32'(a_wreq), 32'(1));
        check("rst_rd", 32'(a_rd), 32'(0));
        check("rst_wr", 32'(a_wr), 32'(0));
        check("rst_addr", 32'(a_addr), 32'(0));
        check("rst_readdata", a_rdata, 32'h0);
        check("rst_timeout", 32'(a_to), 32'(0));
        check("rst_data_released", 32'(a_data), 32'hFF);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset during the strobe of a write drops the transfer at once.
        @(negedge clk);
        sel = 1'b0; av_addr = 8'hAB; av_wdata = 32'h00000077; av_be = 4'b0001; av_wr = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_reset_wr", 32'(a_wr), 32'(1));
        check("pre_reset_data", 32'(a_data), 32'h77);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_wr", 32'(a_wr), 32'(0));
        check("midrst_data", 32'(a_data), 32'hFF);
        check("midrst_waitrequest", 32'(a_wreq), 32'(1));
        check("midrst_addr", 32'(a_addr), 32'(0));
        check("midrst_b_timeout_cleared", 32'(b_to), 32'(0));
        rst_n = 1'b1; av_wr = 1'b0;
        @(negedge clk);
        check("post_reset_idle_wr", 32'(a_wr), 32'(0));
        check("post_reset_idle_wreq", 32'(a_wreq), 32'(1));
        run_vec('{1'b0,1'b1,1'b0,8'h66,8'h00,4'b0000,8'hC9,0,0,2,0,5,32'h000000C9,1'b0});

        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
